food_placement_controller: RTL and testbench

Sequences the free-running coordinate LFSR to place a new food item on the playfield. On request it samples a raw random coordinate, folds it into the legal grid, and queries the snake-occupancy checker over a valid/ready handshake. It retries on collision up to a bounded count, then commits the coordinate to the game renderer or reports failure. It sits between the game-state FSM, the random coordinate source and the snake body memory.

---
 rtl/food_placement_controller.sv | 122 ++++++++++++
 tb/tb_food_placement_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/food_placement_controller.sv
// Food placement controller: samples the free-running coordinate LFSR, folds
// the raw value into the legal grid, asks the snake-occupancy checker whether
// the cell is free, and retries on collision up to MAX_TRIES candidates.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for place_req; food outputs hold the last placement
//   SAMPLE | fold the raw random coordinate and register it as candidate
//   QUERY  | occupancy query outstanding, candidate held until occ_ready
//   FAIL   | every candidate was occupied; leaving emits place_fail
module food_placement_controller #(
  parameter int X_MAX     = 160,
  parameter int Y_MAX     = 120,
  parameter int MAX_TRIES = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       place_req,
  input  logic [7:0] rand_x,
  input  logic [6:0] rand_y,
  output logic       occ_valid,
  output logic [7:0] occ_x,
  output logic [6:0] occ_y,
  input  logic       occ_ready,
  input  logic       occ_hit,
  output logic [7:0] food_x,
  output logic [6:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       place_done,
  output logic       place_fail
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_QUERY  = 2'd2;
  localparam logic [1:0] S_FAIL   = 2'd3;

  // X_MAX may be 256, so the x compare needs a ninth bit.
  localparam logic [8:0] X_LIM   = 9'(X_MAX);
  localparam logic [7:0] Y_LIM   = 8'(Y_MAX);
  localparam logic [7:0] TRY_LIM = 8'(MAX_TRIES);

  logic [1:0] state;
  logic [7:0] tries;
  logic [7:0] try_next;
  logic [7:0] cand_x;
  logic [6:0] cand_y;
  logic [7:0] fold_x;
  logic [6:0] fold_y;
  logic [8:0] x_ext;
  logic [7:0] y_ext;

  // Fold the raw coordinate into the grid; one subtraction is enough because
  // the raw range is less than twice the grid size.
  always_comb begin
    x_ext    = {1'b0, rand_x};
    y_ext    = {1'b0, rand_y};
    fold_x   = rand_x;
    fold_y   = rand_y;
    try_next = tries + 8'd1;
    if (x_ext >= X_LIM) fold_x = 8'(x_ext - X_LIM);
    if (y_ext >= Y_LIM) fold_y = 7'(y_ext - Y_LIM);
  end

  assign occ_valid = (state == S_QUERY);
  assign occ_x     = cand_x;
  assign occ_y     = cand_y;
  assign busy      = (state != S_IDLE);

  // Placement sequencer: state, retry count, candidate and committed food.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      tries      <= 8'd0;
      cand_x     <= 8'd0;
      cand_y     <= 7'd0;
      food_x     <= 8'd0;
      food_y     <= 7'd0;
      food_valid <= 1'b0;
      place_done <= 1'b0;
      place_fail <= 1'b0;
    end else begin
      place_done <= 1'b0;
      place_fail <= 1'b0;
      case (state)
        S_IDLE: begin
          if (place_req) begin
            tries      <= 8'd0;
            food_valid <= 1'b0;
            state      <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          cand_x <= fold_x;
          cand_y <= fold_y;
          state  <= S_QUERY;
        end
        S_QUERY: begin
          if (occ_ready) begin
            if (!occ_hit) begin
              food_x     <= cand_x;
              food_y     <= cand_y;
              food_valid <= 1'b1;
              place_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              tries <= try_next;
              if (try_next == TRY_LIM) state <= S_FAIL;
              else                     state <= S_SAMPLE;
            end
          end
        end
        default: begin
          place_fail <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_placement_controller.sv
// Scoreboard bench for food_placement_controller. The stimulus process pushes
// the expected query coordinates and placement results; the monitor pops and
// compares them as the DUT presents queries and done/fail pulses.
module tb_food_placement_controller;

  logic       clk;
  logic       resetn;
  logic       place_req;
  logic [7:0] rand_x;
  logic [6:0] rand_y;
  logic       occ_valid;
  logic [7:0] occ_x;
  logic [6:0] occ_y;
  logic       occ_ready;
  logic       occ_hit;
  logic [7:0] food_x;
  logic [6:0] food_y;
  logic       food_valid;
  logic       busy;
  logic       place_done;
  logic       place_fail;

  typedef struct {
    bit         fail;
    logic [7:0] x;
    logic [6:0] y;
    int         cyc;
  } res_t;

  logic [14:0] qry_q[$];
  res_t        res_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int hs_cnt      = 0;
  int hs_base     = 0;
  int hits_total  = 0;

  // The bench plays the occupancy checker: the first hits_total handshakes of
  // each request report a collision.
  assign occ_hit = ((hs_cnt - hs_base) < hits_total);

  food_placement_controller #(.X_MAX(160), .Y_MAX(120), .MAX_TRIES(4)) dut (
    .clk(clk), .resetn(resetn), .place_req(place_req),
    .rand_x(rand_x), .rand_y(rand_y),
    .occ_valid(occ_valid), .occ_x(occ_x), .occ_y(occ_y),
    .occ_ready(occ_ready), .occ_hit(occ_hit),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .busy(busy), .place_done(place_done), .place_fail(place_fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Monitor / scoreboard
  initial begin
    logic [34:0] outs;
    logic [14:0] exp_q;
    res_t        r;
    bit          hs;
    forever begin
      @(negedge clk or negedge resetn);
      hs = 1'b0;
      if (!resetn) begin
        #1;
        outs = {occ_valid, occ_x, occ_y, food_x, food_y, food_valid, busy, place_done, place_fail};
        vectors++;
        if (outs != 35'd0) begin
          miscompares++;
          $display("FAIL reset_outputs: got %h want 0 at t=%0t", outs, $time);
        end
      end else begin
        if (occ_valid) begin
          if (qry_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_query: got x=%0d y=%0d want no query", occ_x, occ_y);
          end else begin
            exp_q = qry_q[0];
            vectors++;
            if ({occ_x, occ_y} != exp_q) begin
              miscompares++;
              $display("FAIL query_coord: got x=%0d y=%0d want x=%0d y=%0d",
                       occ_x, occ_y, exp_q[14:7], exp_q[6:0]);
            end
            if (occ_ready) begin
              void'(qry_q.pop_front());
              hs = 1'b1;
            end
          end
        end
        if (place_done || place_fail) begin
          if (res_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_pulse: got done=%0b fail=%0b want none", place_done, place_fail);
          end else begin
            r = res_q.pop_front();
            vectors++;
            if (place_fail != r.fail || place_done != !r.fail) begin
              miscompares++;
              $display("FAIL pulse_kind: got done=%0b fail=%0b want fail=%0b", place_done, place_fail, r.fail);
            end
            vectors++;
            if (busy !== 1'b0) begin
              miscompares++;
              $display("FAIL busy_in_pulse: got %0b want 0", busy);
            end
            vectors++;
            if (r.fail) begin
              if (food_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL fail_food_valid: got %0b want 0", food_valid);
              end
            end else if ({food_valid, food_x, food_y} != {1'b1, r.x, r.y}) begin
              miscompares++;
              $display("FAIL food_commit: got v=%0b x=%0d y=%0d want v=1 x=%0d y=%0d",
                       food_valid, food_x, food_y, r.x, r.y);
            end
            if (r.cyc >= 0) begin
              vectors++;
              if (cyc != r.cyc) begin
                miscompares++;
                $display("FAIL done_latency: got cycle %0d want %0d", cyc, r.cyc);
              end
            end
          end
        end else if (qry_q.size() == 0 && res_q.size() == 0) begin
          vectors++;
          if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_busy: got %0b want 0", busy);
          end
        end
        if (hs) begin
          @(posedge clk);
          #1;
          hs_cnt++;
        end
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 300 && (res_q.size() != 0 || qry_q.size() != 0); i++) @(posedge clk);
    if (res_q.size() != 0 || qry_q.size() != 0) begin
      $display("FAIL drain_timeout: got %0d results %0d queries pending want 0",
               res_q.size(), qry_q.size());
      $fatal(1, "placement did not complete");
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic place(input logic [7:0] rx, input logic [6:0] ry,
                       input logic [7:0] ex, input logic [6:0] ey,
                       input int delay, input int hits, input bit extra);
    int   nq;
    int   e0;
    bit   fail;
    res_t r;
    fail = (hits >= 4);
    nq   = fail ? 4 : hits + 1;
    for (int i = 0; i < nq; i++) qry_q.push_back({ex, ey});
    @(posedge clk); #2;
    rand_x = rx; rand_y = ry;
    hits_total = hits;
    hs_base    = hs_cnt;
    occ_ready  = (delay == 0);
    place_req  = 1'b1;
    @(posedge clk); #2;
    place_req = 1'b0;
    e0 = cyc;
    r.fail = fail; r.x = ex; r.y = ey;
    r.cyc  = (delay == 0 && hits == 0) ? e0 + 2 : -1;
    res_q.push_back(r);
    @(posedge clk); #2;
    if (extra) begin
      place_req = 1'b1;
      @(posedge clk); #2;
      place_req = 1'b0;
    end
    for (int i = 0; i < delay; i++) begin
      rand_x = 8'(100 + 17 * i);
      rand_y = 7'(30 + 9 * i);
      @(posedge clk); #2;
    end
    rand_x = rx; rand_y = ry;
    occ_ready = 1'b1;
    wait_drain();
  endtask

  // Directed stimulus
  initial begin
    resetn = 1'b1; place_req = 1'b0; rand_x = 8'd0; rand_y = 7'd0; occ_ready = 1'b0;
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    repeat (2) @(posedge clk);

    place(8'd37,  7'd12,  8'd37,  7'd12,  0, 0, 1'b0);
    place(8'd255, 7'd127, 8'd95,  7'd7,   0, 0, 1'b0);
    place(8'd160, 7'd120, 8'd0,   7'd0,   0, 0, 1'b0);
    place(8'd159, 7'd119, 8'd159, 7'd119, 0, 0, 1'b0);
    place(8'd50,  7'd20,  8'd50,  7'd20,  5, 0, 1'b0);
    place(8'd10,  7'd5,   8'd10,  7'd5,   0, 3, 1'b1);
    place(8'd200, 7'd100, 8'd40,  7'd100, 0, 4, 1'b0);

    // Abort mid-query: no handshake, no pulse, idle afterwards
    qry_q.push_back({8'd80, 7'd40});
    @(posedge clk); #2;
    rand_x = 8'd80; rand_y = 7'd40; hits_total = 0; hs_base = hs_cnt;
    occ_ready = 1'b0; place_req = 1'b1;
    @(posedge clk); #2;
    place_req = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b0;
    qry_q.delete();
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    occ_ready = 1'b1;
    repeat (6) @(posedge clk);

    place(8'd70, 7'd60, 8'd70, 7'd60, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
